// File: rtl/ahbl_apb_bridge_pkg.sv
// Shared encodings for the AHB-Lite to APB bridge: AHB transfer/response codes and FSM states.
package ahbl_apb_bridge_pkg;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WDATA  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR0   = 3'd4,
    ST_ERR1   = 3'd5
  } bridge_state_t;

  function automatic logic is_valid_trans(input logic [1:0] htrans);
    return (htrans == HTRANS_NSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahbl_apb_bridge_timeout.sv
// APB access-phase wait counter; expired is high once the count reaches LIMIT.
module apb_timeout_ctr #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic cnt_en,
  output logic expired
);

  localparam int unsigned CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt;

  // Saturate at the limit; the bridge leaves ACCESS on that cycle anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      cnt <= '0;
    else if (clear)                  cnt <= '0;
    else if (cnt_en && (cnt != LIM)) cnt <= cnt + CW'(1);
  end

  assign expired = (cnt == LIM);

endmodule

// File: rtl/ahbl_apb_bridge.sv
// AHB-Lite slave to APB master bridge, one APB setup+access per AHB data phase.
// Optional APB access timeout enabled by defining APB_TIMEOUT_EN.
module ahbl_apb_bridge
  import ahbl_apb_bridge_pkg::*;
#(
  parameter int          W_HADDR        = 32,
  parameter int          W_PADDR        = 20,
  parameter int          W_DATA         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ahbls_hready,
  output logic               ahbls_hready_resp,
  output logic               ahbls_hresp,
  input  logic [W_HADDR-1:0] ahbls_haddr,
  input  logic               ahbls_hwrite,
  input  logic [1:0]         ahbls_htrans,
  input  logic [2:0]         ahbls_hsize,
  input  logic [W_DATA-1:0]  ahbls_hwdata,
  output logic [W_DATA-1:0]  ahbls_hrdata,
  output logic [W_PADDR-1:0] apbm_paddr,
  output logic               apbm_psel,
  output logic               apbm_penable,
  output logic               apbm_pwrite,
  output logic [W_DATA-1:0]  apbm_pwdata,
  input  logic [W_DATA-1:0]  apbm_prdata,
  input  logic               apbm_pready,
  input  logic               apbm_pslverr
);

  bridge_state_t state;
  logic          accept;
  logic          tmo_expired;

  assign accept = ahbls_hready && is_valid_trans(ahbls_htrans) &&
                  ((state == ST_IDLE) || (state == ST_ERR1));

`ifdef APB_TIMEOUT_EN
  apb_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == ST_SETUP),
    .cnt_en  ((state == ST_ACCESS) && !apbm_pready),
    .expired (tmo_expired)
  );
`else
  logic unused_tmo;
  assign tmo_expired = 1'b0;
  assign unused_tmo  = (TIMEOUT_CYCLES == 0);
`endif

  // Size is ignored (full-word forwarding) and upper address bits do not reach APB.
  logic unused_in;
  assign unused_in = ^{ahbls_hsize, ahbls_haddr[W_HADDR-1:W_PADDR]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      apbm_psel         <= 1'b0;
      apbm_penable      <= 1'b0;
      apbm_pwrite       <= 1'b0;
      apbm_paddr        <= '0;
      apbm_pwdata       <= '0;
      ahbls_hrdata      <= '0;
      ahbls_hready_resp <= 1'b1;
      ahbls_hresp       <= HRESP_OKAY;
    end else begin
      case (state)
        ST_IDLE, ST_ERR1: begin
          state             <= ST_IDLE;
          ahbls_hready_resp <= 1'b1;
          ahbls_hresp       <= HRESP_OKAY;
          if (accept) begin
            apbm_paddr        <= ahbls_haddr[W_PADDR-1:0];
            apbm_pwrite       <= ahbls_hwrite;
            ahbls_hready_resp <= 1'b0;
            // Writes spend one cycle collecting hwdata before SETUP.
            if (ahbls_hwrite) begin
              state <= ST_WDATA;
            end else begin
              state     <= ST_SETUP;
              apbm_psel <= 1'b1;
            end
          end
        end
        ST_WDATA: begin
          apbm_pwdata <= ahbls_hwdata;
          apbm_psel   <= 1'b1;
          state       <= ST_SETUP;
        end
        ST_SETUP: begin
          apbm_penable <= 1'b1;
          state        <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (apbm_pready) begin
            apbm_psel    <= 1'b0;
            apbm_penable <= 1'b0;
            if (apbm_pslverr) begin
              state       <= ST_ERR0;
              ahbls_hresp <= HRESP_ERROR;
            end else begin
              state             <= ST_IDLE;
              ahbls_hready_resp <= 1'b1;
              if (!apbm_pwrite) ahbls_hrdata <= apbm_prdata;
            end
          end else if (tmo_expired) begin
            apbm_psel    <= 1'b0;
            apbm_penable <= 1'b0;
            state        <= ST_ERR0;
            ahbls_hresp  <= HRESP_ERROR;
          end
        end
        ST_ERR0: begin
          state             <= ST_ERR1;
          ahbls_hready_resp <= 1'b1;
        end
        default: begin
          state             <= ST_IDLE;
          apbm_psel         <= 1'b0;
          apbm_penable      <= 1'b0;
          ahbls_hready_resp <= 1'b1;
          ahbls_hresp       <= HRESP_OKAY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahbl_apb_bridge.sv
// Directed scoreboard bench for ahbl_apb_bridge; build with APB_TIMEOUT_EN to cover the timeout path.
module tb_ahbl_apb_bridge;
  import ahbl_apb_bridge_pkg::*;

  localparam int TMO   = 4;
  localparam int STALL = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ahbls_hready, ahbls_hready_resp, ahbls_hresp;
  logic [31:0] ahbls_haddr;
  logic        ahbls_hwrite;
  logic [1:0]  ahbls_htrans;
  logic [2:0]  ahbls_hsize;
  logic [31:0] ahbls_hwdata, ahbls_hrdata;
  logic [19:0] apbm_paddr;
  logic        apbm_psel, apbm_penable, apbm_pwrite;
  logic [31:0] apbm_pwdata, apbm_prdata;
  logic        apbm_pready, apbm_pslverr;

  always #5 clk = ~clk;

  ahbl_apb_bridge #(.W_HADDR(32), .W_PADDR(20), .W_DATA(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ahbls_hready(ahbls_hready), .ahbls_hready_resp(ahbls_hready_resp), .ahbls_hresp(ahbls_hresp),
    .ahbls_haddr(ahbls_haddr), .ahbls_hwrite(ahbls_hwrite), .ahbls_htrans(ahbls_htrans),
    .ahbls_hsize(ahbls_hsize), .ahbls_hwdata(ahbls_hwdata), .ahbls_hrdata(ahbls_hrdata),
    .apbm_paddr(apbm_paddr), .apbm_psel(apbm_psel), .apbm_penable(apbm_penable),
    .apbm_pwrite(apbm_pwrite), .apbm_pwdata(apbm_pwdata), .apbm_prdata(apbm_prdata),
    .apbm_pready(apbm_pready), .apbm_pslverr(apbm_pslverr)
  );

  // Bus hready follows this slave; hrdy_kill forces an unqualified address phase.
  logic hrdy_kill = 1'b0;
  assign ahbls_hready = ahbls_hready_resp & ~hrdy_kill;

  // APB slave model: pready after s_wait stalled ACCESS cycles.
  int          s_wait  = 0;
  logic        s_err   = 1'b0;
  logic [31:0] s_rdata = '0;
  int          acc_cnt;
  assign apbm_pready  = apbm_psel && apbm_penable && (acc_cnt == s_wait);
  assign apbm_pslverr = apbm_pready && s_err;
  assign apbm_prdata  = s_rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_cnt <= 0;
    else if (apbm_psel && apbm_penable && !apbm_pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  typedef struct { logic [31:0] rdata; logic err; int acc; logic wr; } ahb_exp_t;
  typedef struct { logic [31:0] addr; logic wr; logic [31:0] wdata; } apb_exp_t;
  ahb_exp_t    ahb_q[$];
  apb_exp_t    apb_q[$];
  logic [31:0] last_rd   = '0;
  logic [31:0] cur_wdata = '0;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // APB monitor: signals stable across SETUP/ACCESS, completions match issue order.
  logic [31:0] snap_a, snap_d;
  logic        snap_w;
  apb_exp_t    mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (apbm_psel && !apbm_penable) begin
        snap_a = 32'(apbm_paddr); snap_w = apbm_pwrite; snap_d = apbm_pwdata;
      end else if (apbm_psel && apbm_penable) begin
        chk("apb_paddr_stable", 32'(apbm_paddr), snap_a);
        chk("apb_pwrite_stable", 32'(apbm_pwrite), 32'(snap_w));
        chk("apb_pwdata_stable", apbm_pwdata, snap_d);
        if (apbm_pready) begin
          if (apb_q.size() == 0) chk("apb_unexpected_xfer", 32'(apbm_pready), 32'(0));
          else begin
            mon_e = apb_q.pop_front();
            chk("apb_paddr", 32'(apbm_paddr), mon_e.addr);
            chk("apb_pwrite", 32'(apbm_pwrite), 32'(mon_e.wr));
            if (mon_e.wr) chk("apb_pwdata", apbm_pwdata, mon_e.wdata);
          end
        end
      end
    end
  end

  // Drive an address phase and push expectations; call at a negedge while the DUT can accept.
  task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                       input logic [31:0] rd, input int pw, input logic err);
    ahb_exp_t a;
    apb_exp_t p;
    a.wr = wr; a.err = err; a.acc = pw;
    a.rdata = (!wr && !err) ? rd : last_rd;
    if (!wr && !err) last_rd = rd;
    p.addr = {12'h0, addr[19:0]}; p.wr = wr; p.wdata = wdata;
    if (pw >= STALL) a.acc = TMO;
    else apb_q.push_back(p);
    ahb_q.push_back(a);
    s_wait = pw; s_err = err; s_rdata = rd;
    ahbls_haddr = addr; ahbls_hwrite = wr; ahbls_htrans = HTRANS_NSEQ;
    cur_wdata = wdata;
  endtask

  // Follow one data phase cycle by cycle; returns at the negedge of its final cycle.
  task automatic wait_resp(input string tag);
    ahb_exp_t a;
    int       offs, lat;
    logic     done, es, ee, eh;
    a    = ahb_q.pop_front();
    offs = a.wr ? 1 : 0;
    lat  = 3 + offs + a.acc + (a.err ? 1 : 0);
    @(posedge clk); #1;
    ahbls_htrans = HTRANS_IDLE;
    ahbls_hwdata = cur_wdata;
    done = 1'b0;
    for (int n = 1; n <= lat + 10 && !done; n++) begin
      @(negedge clk);
      es = (n >= 1 + offs) && (n <= 2 + offs + a.acc);
      ee = (n >= 2 + offs) && (n <= 2 + offs + a.acc);
      eh = a.err && (n >= lat - 1);
      chk({tag, "_psel"}, 32'(apbm_psel), 32'(es));
      chk({tag, "_penable"}, 32'(apbm_penable), 32'(ee));
      chk({tag, "_hresp"}, 32'(ahbls_hresp), 32'(eh));
      if (ahbls_hready_resp) begin
        done = 1'b1;
        chk({tag, "_latency"}, 32'(n), 32'(lat));
        chk({tag, "_hrdata"}, ahbls_hrdata, a.rdata);
      end else if (n == 1) begin
        @(posedge clk); #1;
        ahbls_hwdata = 32'hDEAD_BEEF;
      end
    end
    if (!done) chk({tag, "_no_resp"}, 32'(ahbls_hready_resp), 32'(1));
  endtask

  initial begin
    rst_n = 1'b0;
    ahbls_haddr = '0; ahbls_hwrite = 1'b0; ahbls_htrans = HTRANS_IDLE;
    ahbls_hsize = 3'b010; ahbls_hwdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_psel", 32'(apbm_psel), 32'(0));
    chk("rst_penable", 32'(apbm_penable), 32'(0));
    chk("rst_pwrite", 32'(apbm_pwrite), 32'(0));
    chk("rst_paddr", 32'(apbm_paddr), 32'(0));
    chk("rst_pwdata", apbm_pwdata, 32'(0));
    chk("rst_hrdata", ahbls_hrdata, 32'(0));
    chk("rst_hready_resp", 32'(ahbls_hready_resp), 32'(1));
    chk("rst_hresp", 32'(ahbls_hresp), 32'(HRESP_OKAY));
    #1 rst_n = 1'b1;
    @(negedge clk);

    issue(32'h0000_0008, 1'b0, '0, 32'h1234_5678, 0, 1'b0);
    wait_resp("rd8");
    @(negedge clk);
    issue(32'h0000_0004, 1'b1, 32'h0000_0003, 32'hFFFF_0000, 0, 1'b0);
    wait_resp("wr4");
    @(negedge clk);

    issue(32'h0000_0020, 1'b0, '0, 32'h0BAD_0BAD, 5, 1'b1);
    wait_resp("rd_slverr");
    issue(32'h0000_0024, 1'b0, '0, 32'hA5A5_5A5A, 0, 1'b0);
    wait_resp("rd_in_err1");

    issue(32'hF001_0010, 1'b1, 32'hCAFE_0001, '0, 1, 1'b0);
    wait_resp("b2b_wr10");
    issue(32'h0000_0014, 1'b0, '0, 32'h0BAD_F00D, 0, 1'b0);
    wait_resp("b2b_rd14");
    issue(32'h0000_0018, 1'b1, 32'h7777_8888, '0, 2, 1'b1);
    wait_resp("wr_slverr");
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      ahbls_haddr  = 32'h30;
      ahbls_hwrite = 1'b0;
      hrdy_kill    = (i == 0);
      ahbls_htrans = (i == 0) ? HTRANS_NSEQ : (i == 1) ? HTRANS_BUSY : HTRANS_IDLE;
      @(negedge clk);
      chk("ignored_psel", 32'(apbm_psel), 32'(0));
      chk("ignored_hready_resp", 32'(ahbls_hready_resp), 32'(1));
    end
    hrdy_kill = 1'b0;

`ifdef APB_TIMEOUT_EN
    issue(32'h0000_0040, 1'b0, '0, 32'h4040_4040, STALL, 1'b0);
    wait_resp("timeout");
    s_wait = 0;
    @(negedge clk);
`endif

    // Read that stalls in ACCESS, then reset hits mid-transfer.
    s_wait = STALL; s_err = 1'b0;
    ahbls_haddr = 32'h44; ahbls_hwrite = 1'b0; ahbls_htrans = HTRANS_NSEQ;
    @(posedge clk); #1;
    ahbls_htrans = HTRANS_IDLE;
`ifdef APB_TIMEOUT_EN
    repeat (3) @(negedge clk);
`else
    repeat (30) @(negedge clk);
`endif
    chk("stall_psel", 32'(apbm_psel), 32'(1));
    chk("stall_penable", 32'(apbm_penable), 32'(1));
    chk("stall_hready_resp", 32'(ahbls_hready_resp), 32'(0));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_psel", 32'(apbm_psel), 32'(0));
    chk("rst_mid_penable", 32'(apbm_penable), 32'(0));
    chk("rst_mid_hready_resp", 32'(ahbls_hready_resp), 32'(1));
    @(negedge clk);
    chk("rst_hold_hready_resp", 32'(ahbls_hready_resp), 32'(1));
    chk("rst_hold_psel", 32'(apbm_psel), 32'(0));
    last_rd = '0;
    s_wait  = 0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    issue(32'h0000_0048, 1'b0, '0, 32'h55AA_33CC, 0, 1'b0);
    wait_resp("rd_after_rst");
    @(negedge clk);

    chk("ahb_q_empty", 32'(ahb_q.size()), 32'(0));
    chk("apb_q_empty", 32'(apb_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary within the time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
